// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0]  HALT_OP   = 2'b00;
  localparam logic [3:0]  HALT_FUNC = 4'b1111;
  localparam logic [15:0] NOP_INST  = 16'h0000;

  // A HALT slot stops issue instead of being sent to the core.
  function automatic logic is_halt(input logic [15:0] inst);
    return (inst[1:0] == HALT_OP) && (inst[5:2] == HALT_FUNC);
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: assembles byte pairs (low first) into 16-bit slots and
// serves the slot addressed by pc asynchronously.
module seq_prog_mem
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_byte_we,
  input  logic [7:0]    i_byte,
  input  logic [PW-1:0] i_raddr,
  output logic [15:0]   o_rdata,
  output logic          o_pending,
  output logic [PW:0]   o_prog_len
);

  localparam int unsigned LW = PW + 1;

  logic [15:0]   r_mem [DEPTH];
  logic [7:0]    r_low;
  logic          r_pending;
  logic [LW-1:0] r_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_low     <= 8'h00;
      r_len     <= '0;
    end else if (i_clear) begin
      r_pending <= 1'b0;
      r_len     <= '0;
    end else if (i_byte_we) begin
      if (r_pending) begin
        r_pending <= 1'b0;
        r_len     <= r_len + LW'(1);
      end else begin
        r_pending <= 1'b1;
        r_low     <= i_byte;
      end
    end
  end

  // Contents are never reset; prog_len alone says which slots are valid.
  always_ff @(posedge clk) begin
    if (i_byte_we && r_pending && !i_clear) begin
      r_mem[r_len[PW-1:0]] <= {i_byte, r_low};
    end
  end

  assign o_rdata    = r_mem[i_raddr];
  assign o_pending  = r_pending;
  assign o_prog_len = r_len;

endmodule

// File: rtl/inst_sequencer.sv
// Program sequencer: loads a byte-packed program, then issues it to the core
// free-running or single-stepped and captures the core's result and zero flag.
module inst_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  input  logic [7:0]    load_byte,
  output logic          load_ready,
  input  logic          clear,
  input  logic          start,
  input  logic          step,
  input  logic          stop,
  output logic [15:0]   inst_out,
  output logic          inst_valid,
  input  logic [7:0]    result_in,
  input  logic          zero_in,
  output logic [7:0]    last_result,
  output logic          last_zero,
  output logic [PW-1:0] pc,
  output logic [PW:0]   prog_len,
  output logic          busy,
  output logic          done
);

  localparam int unsigned   LW      = PW + 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_pc;
  logic          r_load_ready;
  logic [7:0]    r_last_result;
  logic          r_last_zero;

  logic [15:0]   w_rdata;
  logic          w_pending;
  logic [LW-1:0] w_prog_len;
  logic [LW-1:0] w_len_nxt;
  logic          w_halt;
  logic          w_last_slot;
  logic          w_start_acc;
  logic          w_step_acc;
  logic          w_load_acc;

  seq_prog_mem #(
    .DEPTH(DEPTH),
    .PW   (PW)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (clear),
    .i_byte_we (w_load_acc),
    .i_byte    (load_byte),
    .i_raddr   (r_pc),
    .o_rdata   (w_rdata),
    .o_pending (w_pending),
    .o_prog_len(w_prog_len)
  );

  // Command arbitration: clear > stop > start > step > load.
  assign w_halt      = is_halt(w_rdata);
  assign w_last_slot = (LW'(r_pc) + LW'(1)) == w_prog_len;
  assign w_start_acc = !clear && start && (r_state != RUN) && !w_pending;
  assign w_step_acc  = !clear && step && !w_start_acc && (r_state == IDLE) &&
                       !w_pending && (LW'(r_pc) < w_prog_len);
  assign w_load_acc  = load_valid && r_load_ready && !clear && !w_start_acc &&
                       !w_step_acc && (r_state != RUN);
  assign w_len_nxt   = clear ? '0 : (w_prog_len + LW'(w_load_acc && w_pending));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        RUN: begin
          if (stop)                       w_state_nxt = IDLE;
          else if (w_halt || w_last_slot) w_state_nxt = DONE;
        end
        IDLE, DONE: begin
          if (w_start_acc)
            w_state_nxt = (w_prog_len == '0) ? DONE : RUN;
          else if (w_step_acc && (w_halt || w_last_slot))
            w_state_nxt = DONE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Issue is combinational so stop and reset can suppress it in the same cycle.
  always_comb begin
    inst_valid = 1'b0;
    case (r_state)
      RUN:     inst_valid = !clear && !stop && !w_halt;
      IDLE:    inst_valid = w_step_acc && !w_halt;
      default: inst_valid = 1'b0;
    endcase
    inst_out = inst_valid ? w_rdata : NOP_INST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= '0;
      r_load_ready  <= 1'b0;
      r_last_result <= 8'h00;
      r_last_zero   <= 1'b0;
    end else begin
      r_load_ready <= (w_state_nxt != RUN) && (w_len_nxt < LEN_MAX);
      if (clear || w_start_acc) r_pc <= '0;
      else if (inst_valid)      r_pc <= r_pc + PW'(1);
      if (inst_valid) begin
        r_last_result <= result_in;
        r_last_zero   <= zero_in;
      end
    end
  end

  assign load_ready  = r_load_ready;
  assign last_result = r_last_result;
  assign last_zero   = r_last_zero;
  assign pc          = r_pc;
  assign prog_len    = w_prog_len;
  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: cycle vector table, directed corner
// sequences and randomized programs checked against a transaction-level model.
module tb_inst_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 3;
  localparam int unsigned NV    = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic [7:0]    load_byte = 8'h00;
  logic          load_ready;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   inst_out;
  logic          inst_valid;
  logic [7:0]    result_in;
  logic          zero_in;
  logic [7:0]    last_result;
  logic          last_zero;
  logic [PW-1:0] pc;
  logic [PW:0]   prog_len;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  // Reference expectations for the captured result, carried across tests.
  logic [7:0] m_last = 8'h00;
  logic       m_zero = 1'b0;

  // Tiny core model: op 01 loads imm, op 10 adds imm to the accumulator.
  logic       use_core = 1'b0;
  logic [7:0] tb_res = 8'h00;
  logic       tb_zero = 1'b0;
  logic [7:0] core_acc = 8'h00;
  logic [7:0] core_res;

  always_comb begin
    case (inst_out[1:0])
      2'b01:   core_res = {4'h0, inst_out[15:12]};
      2'b10:   core_res = core_acc + {4'h0, inst_out[15:12]};
      default: core_res = core_acc;
    endcase
  end

  always @(posedge clk) if (inst_valid) core_acc <= core_res;

  assign result_in = use_core ? core_res : tb_res;
  assign zero_in   = use_core ? (core_res == 8'h00) : tb_zero;

  always #5 clk = ~clk;

  inst_sequencer #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_ready (load_ready),
    .clear      (clear),
    .start      (start),
    .step       (step),
    .stop       (stop),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .result_in  (result_in),
    .zero_in    (zero_in),
    .last_result(last_result),
    .last_zero  (last_zero),
    .pc         (pc),
    .prog_len   (prog_len),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic        lv;
    logic [7:0]  lb;
    logic        st;
    logic        sp;
    logic        so;
    logic        cl;
    logic [7:0]  res;
    logic        zr;
    logic        e_iv;
    logic [15:0] e_out;
    logic        e_lr;
    logic        e_busy;
    logic        e_done;
    logic [2:0]  e_pc;
    logic [3:0]  e_len;
    logic [7:0]  e_last;
    logic        e_zero;
  } vec_t;

  vec_t tbl [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic load_prog(input logic [15:0] p [DEPTH], input int n);
    int idx;
    idx = 0;
    for (int c = 0; c < 4 * n + 10 && idx < 2 * n; c++) begin
      load_valid = 1'b1;
      load_byte  = (idx % 2 == 0) ? p[idx / 2][7:0] : p[idx / 2][15:8];
      #3;
      if (load_ready) idx++;
      cyc();
    end
    load_valid = 1'b0;
    check("load_all_bytes", 64'(idx), 64'(2 * n));
  endtask

  // Model: issue runs slot 0 up to the first HALT (or the end); a stop after
  // k issues leaves the remainder to single steps.
  task automatic run_prog(input logic [15:0] p [DEPTH], input int n, input int stop_req);
    int          h;
    int          nrun;
    int          stop_at;
    bit          has_halt;
    bit          exp_iv;
    bit          exp_busy;
    bit          exp_done;
    logic [15:0] exp_out;
    do_clear();
    load_prog(p, n);
    check("prog_len", 64'(prog_len), 64'(n));
    h = n;
    has_halt = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!has_halt && p[k][5:0] == 6'b111100) begin
        h = k;
        has_halt = 1'b1;
      end
    end
    stop_at = (stop_req >= 0 && stop_req < h) ? stop_req : -1;
    nrun    = (stop_at >= 0) ? stop_at : h;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= h + 3; c++) begin
      stop    = (c == stop_at + 1);
      tb_res  = 8'($urandom);
      tb_zero = 1'($urandom);
      exp_iv  = (c <= nrun);
      exp_out = exp_iv ? p[(c - 1) % DEPTH] : 16'h0000;
      if (stop_at >= 0) begin
        exp_busy = (c <= stop_at + 1);
        exp_done = 1'b0;
      end else begin
        exp_done = has_halt ? (c >= h + 2) : (c >= h + 1);
        exp_busy = !exp_done;
      end
      #3;
      check($sformatf("run_c%0d", c), {inst_valid, inst_out, busy, done},
            {exp_iv, exp_out, exp_busy, exp_done});
      if (exp_iv) begin
        m_last = tb_res;
        m_zero = tb_zero;
      end
      cyc();
    end
    stop = 1'b0;
    if (stop_at >= 0) begin
      check("stop_pc", 64'({busy, done, pc}), 64'({1'b0, 1'b0, PW'(stop_at)}));
      for (int k = stop_at; k < n && k <= h; k++) begin
        step    = 1'b1;
        tb_res  = 8'($urandom);
        tb_zero = 1'($urandom);
        exp_iv  = (k < h);
        exp_out = exp_iv ? p[k] : 16'h0000;
        #3;
        check($sformatf("step_k%0d", k), {inst_valid, inst_out}, {exp_iv, exp_out});
        if (exp_iv) begin
          m_last = tb_res;
          m_zero = tb_zero;
        end
        cyc();
        step = 1'b0;
        #3;
        check("step_quiet", 64'(inst_valid), 64'(0));
        cyc();
      end
    end
    check("final", {busy, done, pc, last_result, last_zero},
          {1'b0, 1'b1, PW'(h), m_last, m_zero});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, %0d checks so far", checks);
    $fatal(1);
  end

  initial begin
    logic [15:0] p [DEPTH];
    int          cnt;
    int          n;
    int          hs;
    int          sreq;

    //        lv    lb     st    sp    so    cl    res    zr    iv    out       lr    bsy   dn    pc    len   last   z
    tbl[0]  = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 4'd1, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 4'd1, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 4'd2, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 4'd2, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 4'd3, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 3'd0, 4'd3, 8'h00, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 16'hA5C1, 1'b0, 1'b1, 1'b0, 3'd1, 4'd3, 8'h11, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 16'h0F02, 1'b0, 1'b1, 1'b0, 3'd2, 4'd3, 8'h22, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd3, 4'd3, 8'h33, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd3, 4'd3, 8'h33, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd3, 4'd3, 8'h33, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 8'h33, 1'b1};

    // Reset state
    #12;
    check("reset_outputs", {inst_valid, inst_out, load_ready, busy, done, pc, prog_len, last_result, last_zero}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Cycle vectors: load 3 instructions, run, done, step ignored in DONE, clear
    for (int i = 0; i < NV; i++) begin
      load_valid = tbl[i].lv;
      load_byte  = tbl[i].lb;
      start      = tbl[i].st;
      step       = tbl[i].sp;
      stop       = tbl[i].so;
      clear      = tbl[i].cl;
      tb_res     = tbl[i].res;
      tb_zero    = tbl[i].zr;
      #3;
      check($sformatf("vec%0d", i),
            {inst_valid, inst_out, load_ready, busy, done, pc, prog_len, last_result, last_zero},
            {tbl[i].e_iv, tbl[i].e_out, tbl[i].e_lr, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_pc,
             tbl[i].e_len, tbl[i].e_last, tbl[i].e_zero});
      cyc();
    end
    load_valid = 1'b0; start = 1'b0; step = 1'b0; stop = 1'b0; clear = 1'b0;
    m_last = 8'h33;
    m_zero = 1'b1;

    // HALT in slot 2: LOAD 3, ADD 4, HALT, ADD 9 with the core model
    for (int k = 0; k < DEPTH; k++) p[k] = 16'h0000;
    p[0] = 16'h3001; p[1] = 16'h4002; p[2] = 16'h003C; p[3] = 16'h9002;
    do_clear();
    load_prog(p, 4);
    use_core = 1'b1;
    start = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      #3;
      if (inst_valid) cnt++;
      cyc();
      start = 1'b0;
    end
    use_core = 1'b0;
    check("halt_issue_count", 64'(cnt), 64'(2));
    check("halt_final", {done, pc, last_result, last_zero}, {1'b1, 3'd2, 8'h07, 1'b0});
    m_last = 8'h07;
    m_zero = 1'b0;

    // Overfill: 18 bytes offered, only 16 fit
    do_clear();
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      load_valid = (cnt < 18);
      load_byte  = 8'(cnt);
      #3;
      if (load_valid && load_ready) cnt++;
      cyc();
    end
    load_valid = 1'b1;
    #3;
    check("overfill_accepted", 64'(cnt), 64'(16));
    check("overfill_state", {load_ready, prog_len}, {1'b0, 4'd8});
    load_valid = 1'b0;
    cyc();

    // Start with an empty program, then with a pending low byte
    do_clear();
    start = 1'b1;
    #3;
    check("empty_start_iv", 64'(inst_valid), 64'(0));
    cyc();
    start = 1'b0;
    #3;
    check("empty_start_done", {done, busy, inst_valid}, {1'b1, 1'b0, 1'b0});
    cyc();
    do_clear();
    load_valid = 1'b1;
    load_byte  = 8'h01;
    cyc();
    load_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    #3;
    check("pending_start_ignored", {busy, done, inst_valid, prog_len}, {1'b0, 1'b0, 1'b0, 4'd0});
    cyc();

    // Six instructions, stop in the third issue cycle, then single-step
    p[0] = 16'h1001; p[1] = 16'h2002; p[2] = 16'h3003;
    p[3] = 16'h4011; p[4] = 16'h5021; p[5] = 16'h6031;
    run_prog(p, 6, 2);

    // Randomized programs, some with HALT, some stopped and stepped
    for (int it = 0; it < 25; it++) begin
      n = int'($urandom_range(1, DEPTH));
      for (int k = 0; k < DEPTH; k++) p[k] = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        hs = int'($urandom_range(0, n - 1));
        p[hs][5:0] = 6'b111100;
      end
      if ($urandom_range(0, 1) == 1) sreq = int'($urandom_range(0, DEPTH - 1));
      else                           sreq = -1;
      run_prog(p, n, sreq);
    end

    // Asynchronous reset in the middle of a run
    p[0] = 16'h1001; p[1] = 16'h2002; p[2] = 16'h3003;
    do_clear();
    load_prog(p, 3);
    start = 1'b1;
    cyc();
    start = 1'b0;
    #3;
    check("pre_reset_issue", {inst_valid, inst_out}, {1'b1, 16'h1001});
    rst_n = 1'b0;
    #1;
    check("async_reset", {inst_valid, inst_out, busy, done, pc, prog_len, last_result, last_zero, load_ready}, 64'h0);
    m_last = 8'h00;
    m_zero = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    start = 1'b1;
    #3;
    check("post_reset_start_iv", 64'(inst_valid), 64'(0));
    cyc();
    start = 1'b0;
    #3;
    check("post_reset_done", {done, inst_valid, prog_len}, {1'b1, 1'b0, 4'd0});
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
